// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_param
//  Purpose  : Parametrised single-clock FIFO with programmable almost-full /
//             almost-empty thresholds, occupancy output and sticky
//             overflow / underflow error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_wr,
    input  logic              fifo_rd,
    input  logic [ADDR_W:0]   al_full_th,
    input  logic [ADDR_W:0]   al_empty_th,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   occupancy,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              al_full,
    output logic              al_empty,
    output logic              err_ovf,
    output logic              err_udf,
    output logic              err_fifo
);

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_occ_one = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   c_occ_max = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   occ_q,      occ_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              err_ovf_q,  err_ovf_d;
    logic              err_udf_q,  err_udf_d;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ovf;
    logic w_udf;

    // Status flags are pure compares of the registered count; thresholds are live
    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == c_occ_max);
    assign al_full    = (occ_q >= al_full_th);
    assign al_empty   = (occ_q <= al_empty_th);

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle; a read of an empty FIFO never falls through.
    assign w_rd_ok = fifo_rd & ~fifo_empty;
    assign w_wr_ok = fifo_wr & (~fifo_full | fifo_rd);
    assign w_ovf   = fifo_wr & fifo_full & ~fifo_rd;
    assign w_udf   = fifo_rd & fifo_empty;

    // Next-state for pointers, count, read data and sticky errors
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        data_out_d   = data_out_q;
        data_valid_d = w_rd_ok;
        err_ovf_d    = err_ovf_q;
        err_udf_d    = err_udf_q;

        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_ok) begin
            rd_ptr_d   = rd_ptr_q + c_ptr_one;
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({w_wr_ok, w_rd_ok})
            2'b10:   occ_d = occ_q + c_occ_one;
            2'b01:   occ_d = occ_q - c_occ_one;
            default: occ_d = occ_q;
        endcase

        // A new error in the same cycle as a clear keeps the flag set
        if (w_ovf) begin
            err_ovf_d = 1'b1;
        end else if (err_clr) begin
            err_ovf_d = 1'b0;
        end
        if (w_udf) begin
            err_udf_d = 1'b1;
        end else if (err_clr) begin
            err_udf_d = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_udf_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_ovf_q    <= err_ovf_d;
            err_udf_q    <= err_udf_d;
        end
    end

    // Storage array is not reset; writes in the reset cycle are discarded
    always_ff @(posedge clk) begin
        if (RESET_L && w_wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign occupancy  = occ_q;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;
    assign err_fifo   = err_ovf_q | err_udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_param
//  Purpose  : Self-checking scoreboard bench for fifo_param (DATA_W=6, DEPTH=8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              RESET_L = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              fifo_wr = 1'b0;
    logic              fifo_rd = 1'b0;
    logic [ADDR_W:0]   al_full_th = 4'd6;
    logic [ADDR_W:0]   al_empty_th = 4'd2;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W:0]   occupancy;
    logic              fifo_empty;
    logic              fifo_full;
    logic              al_full;
    logic              al_empty;
    logic              err_ovf;
    logic              err_udf;
    logic              err_fifo;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] last_data = '0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    fifo_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk         (clk),
        .RESET_L     (RESET_L),
        .data_in     (data_in),
        .fifo_wr     (fifo_wr),
        .fifo_rd     (fifo_rd),
        .al_full_th  (al_full_th),
        .al_empty_th (al_empty_th),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .occupancy   (occupancy),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .al_full     (al_full),
        .al_empty    (al_empty),
        .err_ovf     (err_ovf),
        .err_udf     (err_udf),
        .err_fifo    (err_fifo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Flag and count checks against the scoreboard depth and live thresholds
    task automatic check_status();
        int n;
        n = sb_q.size();
        check("occupancy", 32'(occupancy), 32'(n));
        check("fifo_empty", 32'(fifo_empty), 32'(n == 0));
        check("fifo_full", 32'(fifo_full), 32'(n == DEPTH));
        check("al_full", 32'(al_full), 32'(n >= int'(al_full_th)));
        check("al_empty", 32'(al_empty), 32'(n <= int'(al_empty_th)));
        check("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check("err_udf", 32'(err_udf), 32'(m_udf));
        check("err_fifo", 32'(err_fifo), 32'(m_ovf | m_udf));
    endtask

    // One clock of stimulus; expectations are pushed/popped on the scoreboard
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] din,
                        input logic clr);
        int   n;
        logic exp_rd_ok;
        logic exp_wr_ok;
        n         = sb_q.size();
        exp_rd_ok = rd && (n > 0);
        exp_wr_ok = wr && ((n < DEPTH) || rd);
        fifo_wr = wr;
        fifo_rd = rd;
        data_in = din;
        err_clr = clr;
        if (exp_rd_ok) last_data = sb_q.pop_front();
        if (exp_wr_ok) sb_q.push_back(din);
        if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
        else if (clr)                m_ovf = 1'b0;
        if (rd && n == 0)            m_udf = 1'b1;
        else if (clr)                m_udf = 1'b0;
        @(posedge clk);
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        err_clr = 1'b0;
        check("data_valid", 32'(data_valid), 32'(exp_rd_ok));
        check("data_out", 32'(data_out), 32'(last_data));
        check_status();
    endtask

    // Reset cycle with a write request present, which must be ignored
    task automatic do_reset();
        RESET_L = 1'b0;
        fifo_wr = 1'b1;
        data_in = 6'h3F;
        @(posedge clk);
        #1;
        RESET_L = 1'b1;
        fifo_wr = 1'b0;
        sb_q.delete();
        last_data = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check_status();
    endtask

    initial begin
        // Reset state
        do_reset();

        // Fill with 0x01..0x08, then overflow attempt, then clear
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 6'(i), 1'b0);
        step(1'b1, 1'b0, 6'h3F, 1'b0);
        check("ovf_set", 32'(err_ovf), 32'h1);
        step(1'b0, 1'b0, 6'h00, 1'b1);
        check("ovf_clr", 32'(err_fifo), 32'h0);

        // Drain: expect the original eight words in order
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 6'h00, 1'b0);
        check("drained_last", 32'(data_out), 32'h08);

        // Underflow holds data_out; empty rd+wr accepts only the write
        step(1'b0, 1'b1, 6'h00, 1'b0);
        step(1'b1, 1'b1, 6'h15, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b1);
        check("udf_then_read", 32'(data_out), 32'h15);

        // Full FIFO with simultaneous rd+wr for 10 cycles, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 6'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 6'h2A, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 6'h00, 1'b0);
            check("wrap_word", 32'(data_out), 32'h2A);
        end

        // Threshold walk, with a live change of al_full_th at occupancy 6
        al_full_th  = 4'd6;
        al_empty_th = 4'd2;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 6'(i + 3), 1'b0);
            if (sb_q.size() == 6) begin
                al_full_th = 4'd7;
                #1;
                check("al_full_th_live", 32'(al_full), 32'h0);
                al_full_th = 4'd6;
                #1;
                check("al_full_th_back", 32'(al_full), 32'h1);
            end
        end

        // Thresholds beyond DEPTH
        al_full_th  = 4'd15;
        al_empty_th = 4'd9;
        #1;
        check_status();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 6'h00, 1'b0);

        // Reset mid-operation discards contents
        al_full_th  = 4'd6;
        al_empty_th = 4'd2;
        step(1'b1, 1'b0, 6'h2B, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 6'h11, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b0);
        check("post_rst_data", 32'(data_out), 32'h11);

        // Randomised traffic including thresholds, clears and errors
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                al_full_th  = 4'($urandom_range(0, 15));
                al_empty_th = 4'($urandom_range(0, 15));
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
